// File: rtl/mem_loader.sv
// Framed byte-stream loader: writes PM/DM bytes from HDR/ADDR/LEN/DATA/CSUM frames
// and holds the CPU in reset until a GO command is accepted with no prior error.
module mem_loader #(
    parameter int unsigned ADDR_W = 7,
    parameter logic [7:0]  PM_HDR = 8'hA5,
    parameter logic [7:0]  DM_HDR = 8'h5A,
    parameter logic [7:0]  GO_CMD = 8'hC3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              pm_we,
    output logic              dm_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    state_t            state, state_n;
    logic              is_dm, is_dm_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [7:0]        len, len_n;
    logic [7:0]        idx, idx_n;
    logic [7:0]        sum, sum_n;
    logic              pm_we_n, dm_we_n, load_done_n, err_n, cpu_rst_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;
    logic              xfer;

    // Gated by reset so nothing is offered while reset is held.
    assign in_ready = (state != S_RUN) && !reset;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            is_dm     <= 1'b0;
            base      <= '0;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            pm_we     <= 1'b0;
            dm_we     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            load_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            is_dm     <= is_dm_n;
            base      <= base_n;
            len       <= len_n;
            idx       <= idx_n;
            sum       <= sum_n;
            pm_we     <= pm_we_n;
            dm_we     <= dm_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            cpu_rst   <= cpu_rst_n;
            load_done <= load_done_n;
            err       <= err_n;
        end
    end

    always_comb begin
        state_n     = state;
        is_dm_n     = is_dm;
        base_n      = base;
        len_n       = len;
        idx_n       = idx;
        sum_n       = sum;
        pm_we_n     = 1'b0;
        dm_we_n     = 1'b0;
        load_done_n = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        cpu_rst_n   = cpu_rst;
        err_n       = err;
        if (xfer) begin
            unique case (state)
                S_IDLE: begin
                    if (in_data == PM_HDR || in_data == DM_HDR) begin
                        is_dm_n = (in_data == DM_HDR);
                        state_n = S_ADDR;
                    end else if (in_data == GO_CMD) begin
                        if (!err) begin
                            cpu_rst_n = 1'b0;
                            state_n   = S_RUN;
                        end
                    end else begin
                        err_n = 1'b1;
                    end
                end
                S_ADDR: begin
                    base_n  = in_data[ADDR_W-1:0];
                    state_n = S_LEN;
                end
                S_LEN: begin
                    len_n = in_data;
                    if (in_data == 8'd0) begin
                        err_n   = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        idx_n   = '0;
                        sum_n   = '0;
                        state_n = S_DATA;
                    end
                end
                S_DATA: begin
                    pm_we_n     = !is_dm;
                    dm_we_n     = is_dm;
                    mem_addr_n  = base + idx[ADDR_W-1:0];
                    mem_wdata_n = in_data;
                    sum_n       = sum + in_data;
                    idx_n       = idx + 8'd1;
                    if (idx_n == len) state_n = S_CSUM;
                end
                S_CSUM: begin
                    if (in_data == sum) load_done_n = 1'b1;
                    else                err_n       = 1'b1;
                    state_n = S_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: frames are driven at the falling edge and every
// write strobe / done pulse is logged at the falling edge for comparison.
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready, pm_we, dm_we, cpu_rst, load_done, err;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;

    int checks = 0;
    int errors = 0;

    logic [6:0] wa[$];
    logic [7:0] wd[$];
    bit         wk[$];
    int         done_cnt = 0;
    int         both_cnt = 0;

    mem_loader #(.ADDR_W(7), .PM_HDR(8'hA5), .DM_HDR(8'h5A), .GO_CMD(8'hC3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .pm_we(pm_we), .dm_we(dm_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .load_done(load_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pm_we || dm_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            wk.push_back(dm_we);
        end
        if (pm_we && dm_we) both_cnt++;
        if (load_done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        @(negedge clk);
        wa.delete(); wd.delete(); wk.delete();
        done_cnt = 0;
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'hEE;
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_wr(input int i, input bit dm, input int a, input int d);
        if (i < wa.size()) begin
            chk($sformatf("wr%0d_kind", i), int'(wk[i]), int'(dm));
            chk($sformatf("wr%0d_addr", i), int'(wa[i]), a);
            chk($sformatf("wr%0d_data", i), int'(wd[i]), d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_pm_we", pm_we, 0);
        chk("rst_dm_we", dm_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        #1 chk("idle_in_ready", in_ready, 1);

        // PM load of four bytes
        clear_log();
        send(8'hA5); send(8'h00); send(8'h04);
        send(8'h93); send(8'h00); send(8'h80); send(8'h00); send(8'h13);
        idle(2);
        chk("pm_nwr", wa.size(), 4);
        exp_wr(0, 0, 0, 8'h93); exp_wr(1, 0, 1, 8'h00);
        exp_wr(2, 0, 2, 8'h80); exp_wr(3, 0, 3, 8'h00);
        chk("pm_done", done_cnt, 1);
        chk("pm_err", err, 0);

        // DM load, single byte
        clear_log();
        send(8'h5A); send(8'h0C); send(8'h01); send(8'h04); send(8'h04);
        idle(2);
        chk("dm_nwr", wa.size(), 1);
        exp_wr(0, 1, 12, 8'h04);
        chk("dm_done", done_cnt, 1);

        // Address wrap
        clear_log();
        send(8'hA5); send(8'h7E); send(8'h04);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0A);
        idle(2);
        chk("wrap_nwr", wa.size(), 4);
        exp_wr(0, 0, 126, 1); exp_wr(1, 0, 127, 2);
        exp_wr(2, 0, 0, 3);   exp_wr(3, 0, 1, 4);
        chk("wrap_done", done_cnt, 1);
        chk("wrap_err", err, 0);

        // Reset during DATA, then a new DM frame (address upper bit ignored)
        send(8'hA5); send(8'h00); send(8'h04); send(8'h11); send(8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_pm_we", pm_we, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_cpu_rst", cpu_rst, 1);
        clear_log();
        reset = 1'b0;
        send(8'h33); // would be a data byte had the frame survived: now a bad header
        idle(1);
        chk("mid_rst_badhdr_err", err, 1);
        do_reset();
        clear_log();
        send(8'h5A); send(8'h85); send(8'h02); send(8'h10); send(8'h20); send(8'h30);
        idle(2);
        chk("rec_nwr", wa.size(), 2);
        exp_wr(0, 1, 5, 8'h10); exp_wr(1, 1, 6, 8'h20);
        chk("rec_done", done_cnt, 1);
        chk("rec_err", err, 0);

        // Bad checksum, then GO is ignored
        clear_log();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h55); send(8'h00);
        idle(2);
        chk("bad_nwr", wa.size(), 1);
        exp_wr(0, 0, 0, 8'h55);
        chk("bad_done", done_cnt, 0);
        chk("bad_err", err, 1);
        send(8'hC3);
        idle(2);
        chk("bad_go_cpu_rst", cpu_rst, 1);
        chk("bad_go_in_ready", in_ready, 1);

        // Good load then GO; bytes in RUN are not consumed
        do_reset();
        clear_log();
        send(8'hA5); send(8'h10); send(8'h01); send(8'h07); send(8'h07);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hC3;
        chk("pre_go_cpu_rst", cpu_rst, 1);
        @(posedge clk);
        @(negedge clk);
        chk("go_cpu_rst", cpu_rst, 0);
        chk("go_in_ready", in_ready, 0);
        in_data = 8'h5A;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("run_nwr", wa.size(), 1);
        exp_wr(0, 0, 16, 8'h07);
        chk("run_done", done_cnt, 1);
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_in_ready", in_ready, 0);
        chk("run_err", err, 0);

        // Unknown command in a fresh run
        do_reset();
        send(8'hFF);
        idle(1);
        chk("ff_err", err, 1);

        // Zero length in a fresh run
        do_reset();
        clear_log();
        send(8'hA5); send(8'h00); send(8'h00);
        idle(2);
        chk("len0_err", err, 1);
        chk("len0_nwr", wa.size(), 0);
        chk("len0_in_ready", in_ready, 1);
        send(8'hC3);
        idle(2);
        chk("len0_go_cpu_rst", cpu_rst, 1);

        chk("both_we", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule
